// File: rtl/rv32_defs.sv
// Shared RV32 front-end definitions: widths, PC step, NOP encoding,
// fetch FSM state encoding and the fetch-buffer entry payload.
package rv32_defs;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [ILEN-1:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_FAULT = 2'b10
    } fetch_state_e;

    // One buffered instruction as presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO used for the fetch buffer and the issued-address tag queue.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push/push_data  write one entry (accepted when not full, or full with a pop)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push and pop
//   count           number of valid entries
//   head            oldest entry (stale when count is zero)
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_en_c, push_en_c;

    assign pop_en_c  = pop & (cnt_q != '0);
    assign push_en_c = push & ((cnt_q != CW'(DEPTH)) | pop_en_c);

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_en_c) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop_en_c) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push_en_c) - CW'(pop_en_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch stage: holds the PC, issues word reads to instruction
// memory under a credit limit, buffers returned words and hands {instr, instr_pc}
// to decode. Redirects flush the stage and restart fetch at the new PC.
// Optional feature macro: IFETCH_MISALIGN_EN (misaligned redirect -> S_FAULT).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       word read request
//   imem_rsp_valid/data             in-order read response, no backpressure
//   redirect_valid/pc               single-cycle fetch redirect
//   instr_valid/ready, instr, instr_pc  decode handshake
//   fetch_fault                     misaligned-PC fault indication
module ifetch_unit
    import rv32_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   tag_count_unused;
    fetch_entry_t    push_entry, head_entry;
    logic [XLEN-1:0] tag_head;
    logic            push_c, pop_c, flush_c, tag_push_c, tag_pop_c;
    logic            q_nonempty_c, credit_ok_c, req_acc_c, rsp_ok_c;
    logic            redir_bad_c;
    logic [XLEN-1:0] redir_tgt_c;
    logic [CW:0]     in_use_c;

`ifdef IFETCH_MISALIGN_EN
    assign redir_bad_c = redirect_pc[1:0] != 2'b00;
    assign fetch_fault = state_q == S_FAULT;
`else
    logic [1:0] unused_redir_lsbs;
    assign unused_redir_lsbs = redirect_pc[1:0];
    assign redir_bad_c       = 1'b0;
    assign fetch_fault       = 1'b0;
`endif
    assign redir_tgt_c = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit: every word in flight or buffered owns a FIFO slot, so no overflow.
    assign in_use_c       = {1'b0, out_q} + {1'b0, fifo_count};
    assign credit_ok_c    = in_use_c < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = (state_q == S_RUN) & credit_ok_c;
    assign imem_req_addr  = pc_q;
    assign req_acc_c      = imem_req_valid & imem_req_ready;
    // Responses with nothing outstanding belong to requests aborted by reset.
    assign rsp_ok_c       = imem_rsp_valid & (out_q != '0);

    assign q_nonempty_c = fifo_count != '0;
    assign instr_valid  = q_nonempty_c & ~redirect_valid;
    assign instr        = q_nonempty_c ? head_entry.instr : '0;
    assign instr_pc     = q_nonempty_c ? head_entry.pc : '0;
    assign push_entry   = '{pc: tag_head, instr: imem_rsp_data};

    // Next state, PC, counters and FIFO controls; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_d      = out_q + CW'(req_acc_c) - CW'(rsp_ok_c);
        drop_d     = drop_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        flush_c    = 1'b0;
        tag_push_c = 1'b0;
        tag_pop_c  = 1'b0;

        if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end
        if (req_acc_c) begin
            pc_d = pc_q + PC_STEP;
        end

        if (redirect_valid) begin
            // Tag queue is flushed too: dropped responses never consume a tag.
            flush_c = 1'b1;
            drop_d  = out_d;
            pc_d    = redir_tgt_c;
            state_d = redir_bad_c ? S_FAULT : S_RUN;
        end else begin
            pop_c      = instr_valid & instr_ready;
            tag_push_c = req_acc_c;
            if (rsp_ok_c) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push_c    = 1'b1;
                    tag_pop_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    ifetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .flush     (flush_c),
        .count     (fifo_count),
        .head      (head_entry)
    );

    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push_c),
        .push_data (pc_q),
        .pop       (tag_pop_c),
        .flush     (flush_c),
        .count     (tag_count_unused),
        .head      (tag_head)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a fixed-latency memory model plus a stream model of
// the expected fetch address and decode sequences, checked every cycle.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int accepts = 0;
    int pops = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] first_req = 32'h0;
    bit exp_fault = 1'b0;
    bit have_first = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: answers each accepted request exactly lat cycles later, in order.
    always @(posedge clk) begin
        cyc++;
        #1;
        imem_rsp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    end

    // Stream model: decode must see consecutive PCs from the last fetch start,
    // requests must walk the same PCs, and a redirect restarts both streams.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_fault) begin
                chk("fault_flag", 32'(fetch_fault), 32'd1);
                chk("fault_no_req", 32'(imem_req_valid), 32'd0);
                chk("fault_no_instr", 32'(instr_valid), 32'd0);
            end else begin
                chk("no_fault", 32'(fetch_fault), 32'd0);
            end
            if (redirect_valid) begin
                chk("no_pop_on_redirect", 32'(instr_valid), 32'd0);
            end
            if (instr_valid) begin
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr", instr, mem_word(exp_pc));
                if (instr_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (!have_first) begin
                    first_req  = imem_req_addr;
                    have_first = 1'b1;
                end
                chk("req_addr", imem_req_addr, exp_req);
                mq.push_back('{imem_req_addr, cyc + lat});
                exp_req = exp_req + 32'd4;
                accepts++;
            end
            if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    exp_fault = 1'b1;
                end else begin
                    exp_fault = 1'b0;
                    exp_pc    = redirect_pc;
                    exp_req   = redirect_pc;
                end
`else
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
`endif
            end
        end
    end

    task automatic wait_pops(input int n, input int budget, input string name);
        int  base;
        bit  ok;
        base = pops;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pops - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] p);
        @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = p;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
    endtask

    task automatic expect_first(input logic [31:0] tgt, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_valid"}, 32'(ok), 32'd1);
        chk({name, "_pc"}, instr_pc, tgt);
    endtask

    initial begin
        bit found;
        int base;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_no_req", 32'(imem_req_valid), 32'd0);

        // 1: sequential fetch from RESET_PC, 1-cycle memory
        wait_pops(8, 60, "t1_progress");
        chk("t1_first_req", first_req, 32'h0000_0100);

        // 2: decode stalled for 10 cycles after a restart at 0x400
        @(posedge clk);
        #2;
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        base = accepts;
        repeat (10) @(negedge clk);
        #1;
        chk("t2_req_count", 32'(accepts - base), 32'd2);
        chk("t2_req_held", 32'(imem_req_valid), 32'd0);
        chk("t2_instr_valid", 32'(instr_valid), 32'd1);
        chk("t2_head_pc", instr_pc, 32'h0000_0400);
        @(posedge clk);
        #2;
        instr_ready = 1'b1;
        wait_pops(6, 60, "t2_resume");

        // 4: redirect coinciding with a request accept and a response
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (imem_req_valid && imem_req_ready && imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_found_cycle", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        expect_first(32'h0000_0500, "t4_first");
        wait_pops(4, 40, "t4_progress");

        // 5: PC wraps from 0xFFFF_FFFC to 0
        redirect_to(32'hFFFF_FFF8);
        expect_first(32'hFFFF_FFF8, "t5_first");
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid && instr_pc == 32'h0) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_wrapped", 32'(found), 32'd1);
        chk("t5_wrap_instr", instr, 32'hDEAD_BEEF);

        // 6: misaligned redirect
        redirect_to(32'h0000_0202);
`ifdef IFETCH_MISALIGN_EN
        repeat (6) @(negedge clk);
        #1;
        chk("t6_fault_set", 32'(fetch_fault), 32'd1);
        chk("t6_fault_no_req", 32'(imem_req_valid), 32'd0);
`else
        expect_first(32'h0000_0200, "t6_masked");
`endif
        redirect_to(32'h0000_0300);
        expect_first(32'h0000_0300, "t6_resume");
        chk("t6_fault_clear", 32'(fetch_fault), 32'd0);
        wait_pops(4, 40, "t6_progress");

        // 3: 3-cycle memory, redirect with two requests outstanding
        @(posedge clk);
        #2;
        lat = 3;
        wait_pops(4, 80, "t3_settle");
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (mq.size() == 2 && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_found_two_out", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        expect_first(32'h0000_0200, "t3_first");
        chk("t3_first_instr", instr, 32'hDEAD_BCEF);
        wait_pops(6, 100, "t3_progress");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
